// File: rtl/run_splitter_2.sv
// Deals whole sentinel-terminated runs from one FWFT FIFO alternately to two downstream FIFOs.
// Latency: 1 cycle from upstream pop to registered write strobe and data.
// Backpressure: stalls on the current port's ready only; a flush costs one stall and one inject cycle.
module run_splitter_2 #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [2*W-1:0]  i_fifo,
    input  logic            i_fifo_empty,
    output logic            o_fifo_read,
    input  logic            i_flush,
    input  logic            i_fifo_1_ready,
    input  logic            i_fifo_2_ready,
    output logic            o_fifo_1_write,
    output logic            o_fifo_2_write,
    output logic [2*W-1:0]  o_data,
    output logic [CW-1:0]   o_runs_1,
    output logic [CW-1:0]   o_runs_2,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        DEAL1 = 2'd0,
        DEAL2 = 2'd1,
        INJ1  = 2'd2,
        INJ2  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_open;
    logic            w_open_nxt;
    logic            r_flush_pend;
    logic            w_flush_pend_nxt;
    logic            r_wr1;
    logic            r_wr2;
    logic            w_wr1_nxt;
    logic            w_wr2_nxt;
    logic [2*W-1:0]  r_data;
    logic [2*W-1:0]  w_data_nxt;
    logic [CW-1:0]   r_runs_1;
    logic [CW-1:0]   r_runs_2;
    logic            w_inc1;
    logic            w_inc2;
    logic            w_deal;
    logic            w_port2;
    logic            w_rdy;
    logic            w_pop;
    logic            w_key_zero;

    assign w_deal     = (r_state == DEAL1) || (r_state == DEAL2);
    assign w_port2    = (r_state == DEAL2) || (r_state == INJ2);
    assign w_rdy      = w_port2 ? i_fifo_2_ready : i_fifo_1_ready;
    assign w_key_zero = (i_fifo[W-1:0] == '0);
    // Reset gates the pop so upstream is never drained while the block is held in reset.
    assign w_pop      = i_rst_n & w_deal & ~r_flush_pend & ~i_fifo_empty & w_rdy;

    always_comb begin
        w_state_nxt      = r_state;
        w_open_nxt       = r_open;
        w_flush_pend_nxt = r_flush_pend;
        w_wr1_nxt        = 1'b0;
        w_wr2_nxt        = 1'b0;
        w_data_nxt       = r_data;
        w_inc1           = 1'b0;
        w_inc2           = 1'b0;
        case (r_state)
            DEAL1, DEAL2: begin
                if (r_flush_pend) begin
                    w_state_nxt = w_port2 ? INJ2 : INJ1;
                end else if (w_pop) begin
                    w_data_nxt = i_fifo;
                    w_wr1_nxt  = ~w_port2;
                    w_wr2_nxt  = w_port2;
                    if (w_key_zero) begin
                        // A sentinel closes the run, so a flush in the same cycle has nothing to close.
                        w_open_nxt  = 1'b0;
                        w_inc1      = ~w_port2;
                        w_inc2      = w_port2;
                        w_state_nxt = w_port2 ? DEAL1 : DEAL2;
                    end else begin
                        w_open_nxt       = 1'b1;
                        w_flush_pend_nxt = i_flush;
                    end
                end else if (i_flush && r_open) begin
                    w_flush_pend_nxt = 1'b1;
                end
            end
            default: begin
                if (w_rdy) begin
                    w_data_nxt       = '0;
                    w_wr1_nxt        = ~w_port2;
                    w_wr2_nxt        = w_port2;
                    w_open_nxt       = 1'b0;
                    w_flush_pend_nxt = 1'b0;
                    w_inc1           = ~w_port2;
                    w_inc2           = w_port2;
                    w_state_nxt      = w_port2 ? DEAL1 : DEAL2;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= DEAL1;
            r_open       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_wr1        <= 1'b0;
            r_wr2        <= 1'b0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_open       <= w_open_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            r_wr1        <= w_wr1_nxt;
            r_wr2        <= w_wr2_nxt;
            r_data       <= w_data_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_runs_1 <= '0;
            r_runs_2 <= '0;
        end else begin
            if (w_inc1) r_runs_1 <= r_runs_1 + CW'(1);
            if (w_inc2) r_runs_2 <= r_runs_2 + CW'(1);
        end
    end

    assign o_fifo_read    = w_pop;
    assign o_fifo_1_write = r_wr1;
    assign o_fifo_2_write = r_wr2;
    assign o_data         = r_data;
    assign o_runs_1       = r_runs_1;
    assign o_runs_2       = r_runs_2;
    assign o_busy         = r_open | r_flush_pend | ~w_deal;

endmodule

// File: tb/tb_run_splitter_2.sv
// Bench for run_splitter_2: directed cases plus randomized traffic against a run-level model.
module tb_run_splitter_2;
    localparam int W  = 32;
    localparam int CW = 8;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [2*W-1:0]  i_fifo = '0;
    logic            i_fifo_empty = 1'b1;
    logic            o_fifo_read;
    logic            i_flush = 1'b0;
    logic            i_fifo_1_ready = 1'b0;
    logic            i_fifo_2_ready = 1'b0;
    logic            o_fifo_1_write;
    logic            o_fifo_2_write;
    logic [2*W-1:0]  o_data;
    logic [CW-1:0]   o_runs_1;
    logic [CW-1:0]   o_runs_2;
    logic            o_busy;

    run_splitter_2 #(.W(W), .CW(CW)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_fifo         (i_fifo),
        .i_fifo_empty   (i_fifo_empty),
        .o_fifo_read    (o_fifo_read),
        .i_flush        (i_flush),
        .i_fifo_1_ready (i_fifo_1_ready),
        .i_fifo_2_ready (i_fifo_2_ready),
        .o_fifo_1_write (o_fifo_1_write),
        .o_fifo_2_write (o_fifo_2_write),
        .o_data         (o_data),
        .o_runs_1       (o_runs_1),
        .o_runs_2       (o_runs_2),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int nreads = 0;
    int cap1_last_cyc = 0;

    logic [63:0] up_q[$];
    logic [63:0] sent_q[$];
    logic [63:0] cap1[$];
    logic [63:0] cap2[$];

    // Model: current port, whether the run holds data, flush phase (0 dealing, 1 stall, 2 inject).
    int          m_port;
    bit          m_open;
    int          m_phase;
    logic [CW-1:0] m_runs[2];
    logic [63:0] m_data;
    bit          m_wr[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] at1(input int i);
        return (i < cap1.size()) ? cap1[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] at2(input int i);
        return (i < cap2.size()) ? cap2[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] rnd_word();
        logic [31:0] k;
        k = $urandom;
        if ($urandom_range(0, 4) == 0) k = '0;
        else if (k == '0) k = 32'd1;
        return {32'($urandom), k};
    endfunction

    task automatic model_reset();
        m_port = 0; m_open = 0; m_phase = 0;
        m_runs[0] = '0; m_runs[1] = '0;
        m_data = '0; m_wr[0] = 0; m_wr[1] = 0;
    endtask

    task automatic step(input bit fl, input bit r1, input bit r2, input bit gap);
        bit          rdy;
        bit          ep;
        logic [63:0] w;
        @(negedge i_clk);
        cyc++;
        chk("wr1", o_fifo_1_write, m_wr[0]);
        chk("wr2", o_fifo_2_write, m_wr[1]);
        chk("data", o_data, m_data);
        chk("runs1", o_runs_1, m_runs[0]);
        chk("runs2", o_runs_2, m_runs[1]);
        chk("busy", o_busy, m_open || (m_phase != 0));
        if (o_fifo_1_write) begin cap1.push_back(o_data); cap1_last_cyc = cyc; end
        if (o_fifo_2_write) cap2.push_back(o_data);
        i_fifo_1_ready = r1;
        i_fifo_2_ready = r2;
        i_flush        = fl;
        i_fifo_empty   = gap || (up_q.size() == 0);
        i_fifo         = (up_q.size() != 0) ? up_q[0] : {32'($urandom), 32'($urandom)};
        #1;
        rdy = (m_port == 0) ? r1 : r2;
        w   = i_fifo;
        ep  = (m_phase == 0) && !i_fifo_empty && rdy;
        chk("read", o_fifo_read, ep);
        m_wr[0] = 0; m_wr[1] = 0;
        if (m_phase == 0) begin
            if (ep) begin
                m_data = w;
                m_wr[m_port] = 1;
                if (w[W-1:0] == '0) begin
                    m_runs[m_port] = m_runs[m_port] + CW'(1);
                    m_open = 0;
                    m_port = 1 - m_port;
                end else begin
                    m_open = 1;
                    if (fl) m_phase = 1;
                end
            end else if (fl && m_open) begin
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (rdy) begin
            m_data = '0;
            m_wr[m_port] = 1;
            m_runs[m_port] = m_runs[m_port] + CW'(1);
            m_open = 0;
            m_phase = 0;
            m_port = 1 - m_port;
        end
        if (o_fifo_read && up_q.size() != 0) begin
            sent_q.push_back(up_q.pop_front());
            nreads++;
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_fifo_empty = 1'b1;
        i_flush      = 1'b0;
        i_rst_n      = 1'b0;
        #1;
        chk("rst_wr1", o_fifo_1_write, 0);
        chk("rst_wr2", o_fifo_2_write, 0);
        chk("rst_data", o_data, 0);
        chk("rst_runs1", o_runs_1, 0);
        chk("rst_runs2", o_runs_2, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_read", o_fifo_read, 0);
        model_reset();
        cap1.delete(); cap2.delete(); sent_q.delete(); up_q.delete();
        nreads = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Rebuild the upstream order by alternating runs between the two port streams.
    task automatic merge_check(input string nm);
        logic [63:0] m[$];
        logic [63:0] a[$];
        logic [63:0] b[$];
        logic [63:0] w;
        int p  = 0;
        int i1 = 0;
        int i2 = 0;
        bit ok = 1;
        while (1) begin
            if (p == 0) begin
                if (i1 >= cap1.size()) break;
                w = cap1[i1]; i1++;
            end else begin
                if (i2 >= cap2.size()) break;
                w = cap2[i2]; i2++;
            end
            m.push_back(w);
            if (w[W-1:0] == '0) p = 1 - p;
        end
        if (i1 != cap1.size() || i2 != cap2.size()) ok = 0;
        foreach (m[i]) if (m[i][W-1:0] != '0) a.push_back(m[i]);
        foreach (sent_q[i]) if (sent_q[i][W-1:0] != '0) b.push_back(sent_q[i]);
        chk({nm, "_len"}, a.size(), b.size());
        if (a.size() != b.size()) ok = 0;
        else foreach (a[i]) if (a[i] !== b[i]) ok = 0;
        chk(nm, ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs;
        int bound;
        model_reset();

        // Two runs, both ports always ready.
        do_reset();
        up_q = '{64'd5, 64'd9, 64'd0, 64'd3, 64'd0};
        repeat (5) step(0, 1, 1, 0);
        chk("t1_drained", up_q.size(), 0);
        chk("t1_reads", nreads, 5);
        repeat (3) step(0, 1, 1, 0);
        chk("t1_p1_n", cap1.size(), 3);
        chk("t1_p1_0", at1(0), 64'd5);
        chk("t1_p1_1", at1(1), 64'd9);
        chk("t1_p1_2", at1(2), 64'd0);
        chk("t1_p2_n", cap2.size(), 2);
        chk("t1_p2_0", at2(0), 64'd3);
        chk("t1_p2_1", at2(1), 64'd0);
        chk("t1_runs1", o_runs_1, 1);
        chk("t1_runs2", o_runs_2, 1);

        // Port 1 not ready for three cycles.
        do_reset();
        up_q = '{64'd5, 64'd9, 64'd0, 64'd3, 64'd0};
        repeat (3) step(0, 0, 1, 0);
        chk("t2_stall", up_q.size(), 5);
        repeat (8) step(0, 1, 1, 0);
        chk("t2_p1_n", cap1.size(), 3);
        chk("t2_p1_1", at1(1), 64'd9);
        chk("t2_p2_0", at2(0), 64'd3);
        chk("t2_runs2", o_runs_2, 1);

        // Flush of an open run with upstream empty.
        do_reset();
        up_q = '{64'd7, 64'd8};
        repeat (2) step(0, 1, 1, 0);
        fs = cyc + 1;
        step(1, 1, 1, 0);
        repeat (4) step(0, 1, 1, 0);
        chk("t3_p1_n", cap1.size(), 3);
        chk("t3_p1_2", at1(2), 64'd0);
        chk("t3_zero_cyc", cap1_last_cyc, fs + 3);
        chk("t3_runs1", o_runs_1, 1);
        chk("t3_busy", o_busy, 0);
        up_q = '{64'd11, 64'd0};
        repeat (4) step(0, 1, 1, 0);
        chk("t3_p2_0", at2(0), 64'd11);
        chk("t3_p2_n", cap2.size(), 2);

        // Flush alongside a sentinel pop, then flush of an empty run.
        do_reset();
        up_q = '{64'd4, 64'd0};
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        repeat (3) step(0, 1, 1, 0);
        chk("t4_runs1", o_runs_1, 1);
        chk("t4_p1_n", cap1.size(), 2);
        step(1, 1, 1, 0);
        repeat (3) step(0, 1, 1, 0);
        chk("t4_runs2", o_runs_2, 0);
        chk("t4_p2_n", cap2.size(), 0);

        // Reset while a run is open and a write strobe is pending.
        do_reset();
        up_q = '{64'd6, 64'd7};
        repeat (2) step(0, 1, 1, 0);
        do_reset();
        up_q = '{64'd9, 64'd0};
        repeat (4) step(0, 1, 1, 0);
        chk("t6_p1_n", cap1.size(), 2);
        chk("t6_p1_0", at1(0), 64'd9);
        chk("t6_p2_n", cap2.size(), 0);

        // Counter wrap: 2*(2^CW+1) empty runs.
        do_reset();
        repeat (2 * ((1 << CW) + 1)) up_q.push_back(64'd0);
        bound = 0;
        while (up_q.size() != 0 && bound < 2000) begin
            step(0, 1, 1, 0);
            bound++;
        end
        repeat (3) step(0, 1, 1, 0);
        chk("t5_drain", up_q.size(), 0);
        chk("t5_runs1", o_runs_1, 1);
        chk("t5_runs2", o_runs_2, 1);
        chk("t5_p1_n", cap1.size(), (1 << CW) + 1);
        chk("t5_p2_n", cap2.size(), (1 << CW) + 1);
        merge_check("t5_merge");

        // Randomized traffic with flushes and backpressure.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0 && up_q.size() < 8) up_q.push_back(rnd_word());
            step($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
        end
        bound = 0;
        while (up_q.size() != 0 && bound < 200) begin
            step(0, 1, 1, 0);
            bound++;
        end
        repeat (4) step(0, 1, 1, 0);
        chk("rnd_drain", up_q.size(), 0);
        merge_check("rnd_merge");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
